// File: rtl/seg7_pkg.sv
// Seven-segment encoding shared by the scanned display and the top-level decoder.
// Patterns are active-low, bit6 = a ... bit0 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] HEX7 [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] hex7(input logic [3:0] v);
    return HEX7[v];
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Digit-slot timer: prescaler dwell per digit, round-robin digit index,
// and a guard flag covering the first GUARD cycles of every slot.
module seg7_scan_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1024,
  parameter int GUARD       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [$clog2(NUM_DIGITS)-1:0] index,
  output logic                          guard
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0] presc;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      index <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      index <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign guard = (presc < PW'(GUARD));

endmodule

// File: rtl/seg7_scan_display.sv
// Captures read results into a newest-first history and scans it onto a
// common-anode display; all outputs are registered off timer and history state.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1024,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            data_in,
  input  logic                  data_valid,
  input  logic                  clr,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [2:0]            fill
);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS-1:0][3:0] digit;
  logic [IW-1:0]              index;
  logic                       guard;
  logic [6:0]                 seg_nxt;
  logic                       dp_nxt;
  logic [NUM_DIGITS-1:0]      anode_nxt;

  seg7_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD      (GUARD)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .index(index),
    .guard(guard)
  );

  // clr beats a same-cycle capture; fill saturates and the oldest entry falls off.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= '0;
      fill  <= '0;
    end else if (data_valid) begin
      digit <= {digit[NUM_DIGITS-2:0], data_in};
      if ({1'b0, fill} < 4'(NUM_DIGITS))
        fill <= fill + 3'd1;
    end
  end

  always_comb begin
    anode_nxt = '1;
    seg_nxt   = SEG_BLANK;
    dp_nxt    = 1'b1;
    if (!guard) begin
      anode_nxt[index] = 1'b0;
      if (4'(index) < {1'b0, fill}) begin
        seg_nxt = hex7(digit[index]);
        dp_nxt  = (index != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode <= '1;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      anode <= anode_nxt;
      seg   <= seg_nxt;
      dp    <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed scenarios plus random traffic against a
// queue-based model of the history and a cycle-count model of the scan timing.
module tb_seg7_scan_display;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GD = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    data_in = '0;
  logic          data_valid = 1'b0;
  logic          clr = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] anode;
  logic [2:0]    fill;

  seg7_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clr(clr),
    .seg(seg), .dp(dp), .anode(anode), .fill(fill)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tb [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t = cycles since reset (slot position), q = history newest-first.
  int         t = 0;
  int         q[$];
  bit         mvalid = 1'b0;
  logic [3:0] e_anode;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [2:0] e_fill;

  initial forever begin
    int pre, ix;
    @(posedge clk);
    if (rst) begin
      e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      q.delete(); t = 0; mvalid = 1'b1;
    end else begin
      pre = t % RD;
      ix  = (t / RD) % ND;
      e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (pre >= GD) begin
        e_anode = 4'hF & ~(4'b0001 << ix);
        if (ix < q.size()) begin
          e_seg = hex_tb[q[ix]];
          e_dp  = (ix != 0);
        end
      end
      t++;
      if (clr) q.delete();
      else if (data_valid) begin
        q.push_front(int'(data_in));
        if (q.size() > ND) void'(q.pop_back());
      end
    end
    e_fill = 3'(q.size());
  end

  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      chk("model_anode", anode, e_anode);
      chk("model_seg", seg, e_seg);
      chk("model_dp", dp, e_dp);
      chk("model_fill", fill, e_fill);
    end
  end

  // Step to the negedge where the timer sits at (digit, prescaler).
  task automatic wait_slot(input int d, input int p);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((t % RD) == p && ((t / RD) % ND) == d) return;
    end
    chk("wait_slot_timeout", 1, 0);
  endtask

  task automatic push(input logic [3:0] v);
    @(negedge clk); data_valid = 1'b1; data_in = v;
    @(negedge clk); data_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] a [10];
    logic [6:0] exp_seg [4];
    int bad;

    repeat (3) @(negedge clk);
    chk("reset_anode", anode, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    chk("reset_fill", fill, 3'd0);
    rst = 1'b0;

    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      a[k] = anode;
      if (seg !== 7'h7F) bad++;
    end
    chk("scan_k0_guard", a[0], 4'hF);
    chk("scan_k1_d0", a[1], 4'hE);
    chk("scan_k7_d0", a[7], 4'hE);
    chk("scan_k8_guard", a[8], 4'hF);
    chk("scan_k9_d1", a[9], 4'hD);
    chk("scan_blank_seg", bad, 0);

    push(4'hA);
    chk("fill_after_A", fill, 3'd1);
    wait_slot(0, 3);
    chk("A_seg", seg, 7'b0001000);
    chk("A_dp", dp, 1'b0);
    chk("A_anode", anode, 4'b1110);
    wait_slot(1, 3);
    chk("d1_blank_seg", seg, 7'h7F);
    chk("d1_blank_dp", dp, 1'b1);

    for (int v = 1; v <= 5; v++) push(4'(v));
    chk("fill_sat", fill, 3'd4);
    exp_seg[0] = 7'b0100100; exp_seg[1] = 7'b1001100;
    exp_seg[2] = 7'b0000110; exp_seg[3] = 7'b0010010;
    for (int d = 0; d < ND; d++) begin
      wait_slot(d, 4);
      chk($sformatf("hist_seg_d%0d", d), seg, exp_seg[d]);
    end

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    push(4'h8); push(4'h9); push(4'hB);
    chk("fill_3", fill, 3'd3);
    data_valid = 1'b1; data_in = 4'h7; clr = 1'b1;
    @(negedge clk); data_valid = 1'b0; clr = 1'b0;
    chk("clr_wins_fill", fill, 3'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (seg !== 7'h7F || seg === 7'b0001111) bad++;
    end
    chk("clr_all_blank", bad, 0);

    push(4'h3);
    wait_slot(2, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_anode", anode, 4'hF);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_dp", dp, 1'b1);
    chk("midrst_fill", fill, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_guard", anode, 4'hF);
    @(negedge clk);
    chk("restart_d0", anode, 4'hE);

    wait_slot(0, 2);
    data_valid = 1'b1; data_in = 4'hF;
    @(negedge clk); data_valid = 1'b0;
    chk("F_edge1_seg", seg, 7'h7F);
    @(negedge clk);
    chk("F_edge2_seg", seg, 7'b0111000);
    chk("F_edge2_anode", anode, 4'hE);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      data_valid = ($urandom_range(3) == 0);
      data_in    = 4'($urandom);
      clr        = ($urandom_range(63) == 0);
      rst        = ($urandom_range(499) == 0);
    end
    @(negedge clk);
    data_valid = 1'b0; clr = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
